bp_stream_pump_out: RTL and testbench

Converts per-beat FSM output (header plus one stream-width data word per beat) into a BedRock xce memory stream.
- Multi-beat messages are emitted as N locked beats; single-beat messages are emitted as one unlocked beat.
- It is the transmit-side partner of the stream receive pump and sits between the cce_to_cache / mem FSMs and the wormhole/stream bus.
- The stream side is registered through a two-entry buffer.

---
 rtl/bp_stream_pump_out.sv | 213 +++++++++++++++++++++
 tb/tb_bp_stream_pump_out.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_stream_pump_out.sv
// Purpose: converts per-beat FSM output (header + one stream word per beat) into
//          a BedRock xce memory stream; multi-beat messages leave as locked beats.
// Latency: a beat accepted at cycle t appears on mem_* at t+1; 1 beat/cycle sustained.
// Backpressure: two-entry output buffer; fsm_ready_and_o drops while it is full,
//               mem_* stay stable while mem_ready_and_i is low.
//
// Ports:
//   clk_i, reset_n_i            clock, asynchronous active-low reset
//   fsm_header_i/_data_i/_v_i   beat from the FSM (header addr = critical word, size = payload)
//   fsm_ready_and_o             beat accepted when fsm_v_i & fsm_ready_and_o
//   fsm_addr_o                  address of the beat the FSM must present this cycle
//   fsm_new_o / fsm_done_o      first / last beat of a message accepted this cycle
//   mem_header_o/_data_o/_v_o   stream beat toward the bus
//   mem_lock_o                  more beats of this message follow
//   mem_ready_and_i             bus accepts a beat when mem_v_o & mem_ready_and_i
//
// Header layout: {payload, msg_type[3:0], size[2:0], addr[paddr_width_p-1:0]};
// msg_type rd=0, wr=1, uc_rd=2, uc_wr=3; payload bytes = 1 << size.
// Optional macro BP_STREAM_PUMP_OUT_BEAT_ADDR_EN: each beat's header addr carries
// that beat's own address instead of the critical-word address.

module bp_stream_pump_out #(
  parameter int paddr_width_p       = 40,
  parameter int payload_width_p     = 16,
  parameter int stream_data_width_p = 64,
  parameter int block_width_p       = 512,
  parameter bit master_p            = 1'b1,
  localparam int hdr_width_lp       = payload_width_p + 4 + 3 + paddr_width_p
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic [hdr_width_lp-1:0]        fsm_header_i,
  input  logic [stream_data_width_p-1:0] fsm_data_i,
  input  logic                           fsm_v_i,
  output logic                           fsm_ready_and_o,
  output logic [paddr_width_p-1:0]       fsm_addr_o,
  output logic                           fsm_new_o,
  output logic                           fsm_done_o,
  output logic [hdr_width_lp-1:0]        mem_header_o,
  output logic [stream_data_width_p-1:0] mem_data_o,
  output logic                           mem_v_o,
  output logic                           mem_lock_o,
  input  logic                           mem_ready_and_i
);

  localparam int stream_words_lp  = block_width_p / stream_data_width_p;
  localparam int data_len_lp      = $clog2(stream_words_lp);
  localparam int stream_bytes_lp  = stream_data_width_p / 8;
  localparam int stream_offset_lp = $clog2(stream_bytes_lp);
  localparam int upper_lsb_lp     = stream_offset_lp + data_len_lp;
  localparam int size_lsb_lp      = paddr_width_p;
  localparam int type_lsb_lp      = paddr_width_p + 3;

  localparam logic [3:0] msg_rd_lp    = 4'd0;
  localparam logic [3:0] msg_wr_lp    = 4'd1;
  localparam logic [3:0] msg_uc_rd_lp = 4'd2;
  localparam logic [3:0] msg_uc_wr_lp = 4'd3;

  typedef enum logic {e_ready, e_stream} state_e;

  state_e                    state_q, state_d;
  logic [data_len_lp-1:0]    cnt_q, cnt_d;
  logic [data_len_lp-1:0]    last_cnt_q;
  logic [hdr_width_lp-1:0]   hdr_q;

  // Header decode of the incoming beat.
  logic [paddr_width_p-1:0]  in_addr;
  logic [2:0]                in_size;
  logic [3:0]                in_type;
  logic [data_len_lp-1:0]    first_cnt, last_cnt, num_m1, cur_cnt;
  logic [stream_offset_lp-1:0] low_bits;
  logic [31:0]               msg_bytes, beats_raw, num_stream;
  logic                      is_wr, is_rd, multi, at_last, accept;

  assign in_addr   = fsm_header_i[paddr_width_p-1:0];
  assign in_size   = fsm_header_i[size_lsb_lp +: 3];
  assign in_type   = fsm_header_i[type_lsb_lp +: 4];
  assign first_cnt = in_addr[stream_offset_lp +: data_len_lp];

  // Beat count = payload / beat width, at least one, at most one full block.
  always_comb begin
    msg_bytes = 32'd1 << in_size;
    beats_raw = msg_bytes / 32'(stream_bytes_lp);
    if (beats_raw == 32'd0)                       num_stream = 32'd1;
    else if (beats_raw > 32'(stream_words_lp))    num_stream = 32'(stream_words_lp);
    else                                          num_stream = beats_raw;
    num_m1 = data_len_lp'(num_stream - 32'd1);
  end

  // Last beat index wraps within the block.
  assign last_cnt = first_cnt + num_m1;
  assign is_wr    = (in_type == msg_wr_lp) || (in_type == msg_uc_wr_lp);
  assign is_rd    = (in_type == msg_rd_lp) || (in_type == msg_uc_rd_lp);
  assign multi    = (master_p ? is_wr : is_rd) && (num_stream > 32'd1);
  assign at_last  = (cnt_q == last_cnt_q);

  // Two-entry output buffer.
  logic [hdr_width_lp-1:0]        buf_hdr_q  [2];
  logic [stream_data_width_p-1:0] buf_data_q [2];
  logic [1:0]                     buf_lock_q;
  logic                           wr_ptr_q, rd_ptr_q;
  logic [1:0]                     count_q;
  logic                           full, enq, deq, enq_lock;
  logic [hdr_width_lp-1:0]        enq_hdr;

  assign full = (count_q == 2'd2);
  // Gated by reset so the FSM sees "not ready" the moment reset asserts.
  assign fsm_ready_and_o = reset_n_i & ~full;
  assign accept = fsm_v_i & fsm_ready_and_o;
  assign enq    = accept;
  assign deq    = mem_v_o & mem_ready_and_i;

  assign mem_v_o      = (count_q != 2'd0);
  assign mem_header_o = buf_hdr_q[rd_ptr_q];
  assign mem_data_o   = buf_data_q[rd_ptr_q];
  assign mem_lock_o   = mem_v_o & buf_lock_q[rd_ptr_q];

  // Beat address: live upper bits, beat index, and the critical word's byte offset.
  assign cur_cnt  = (state_q == e_ready) ? first_cnt : cnt_q;
  assign low_bits = (state_q == e_ready) ? in_addr[stream_offset_lp-1:0]
                                         : hdr_q[stream_offset_lp-1:0];
  assign fsm_addr_o = reset_n_i ? {in_addr[paddr_width_p-1:upper_lsb_lp], cur_cnt, low_bits}
                                : '0;

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= e_ready;
      cnt_q      <= '0;
      last_cnt_q <= '0;
      hdr_q      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == e_ready && accept) begin
        last_cnt_q <= last_cnt;
        hdr_q      <= fsm_header_i;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      e_ready: begin
        if (accept && multi) begin
          state_d = e_stream;
          cnt_d   = first_cnt + 1'b1;
        end
      end
      e_stream: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (at_last) state_d = e_ready;
        end
      end
      default: ;
    endcase
  end

  // Output logic.
  always_comb begin
    fsm_new_o  = 1'b0;
    fsm_done_o = 1'b0;
    enq_lock   = 1'b0;
    case (state_q)
      e_ready: begin
        fsm_new_o  = accept;
        enq_lock   = multi;
        fsm_done_o = accept & ~multi;
      end
      e_stream: begin
        enq_lock   = ~at_last;
        fsm_done_o = accept & at_last;
      end
      default: ;
    endcase
  end

  // Mid-message beats reuse the header captured on the first beat, so its addr
  // is already the critical-word address.
  always_comb begin
    enq_hdr = (state_q == e_ready) ? fsm_header_i : hdr_q;
`ifdef BP_STREAM_PUMP_OUT_BEAT_ADDR_EN
    enq_hdr[paddr_width_p-1:0] = fsm_addr_o;
`endif
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < 2; i++) begin
        buf_hdr_q[i]  <= '0;
        buf_data_q[i] <= '0;
      end
      buf_lock_q <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      if (enq) begin
        buf_hdr_q[wr_ptr_q]  <= enq_hdr;
        buf_data_q[wr_ptr_q] <= fsm_data_i;
        buf_lock_q[wr_ptr_q] <= enq_lock;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (deq) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(enq) - 2'(deq);
    end
  end

endmodule

// File: tb/tb_bp_stream_pump_out.sv
// Purpose: bench for bp_stream_pump_out (master and client instances).
// Latency: n/a.
// Backpressure: bus ready driven from directed holds and random toggling.

module tb_bp_stream_pump_out;

  localparam int PA = 40;
  localparam int PL = 16;
  localparam int HW = PL + 4 + 3 + PA;
  localparam int DW = 64;

  localparam logic [3:0] RD   = 4'd0;
  localparam logic [3:0] WR   = 4'd1;
  localparam logic [3:0] UCRD = 4'd2;
  localparam logic [3:0] UCWR = 4'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic [HW-1:0] fsm_header;
  logic [DW-1:0] fsm_data;
  logic          fsm_v, mem_rdy, use_client;

  logic fsm_v_m, fsm_v_c, mem_rdy_m, mem_rdy_c;
  assign fsm_v_m   = fsm_v & ~use_client;
  assign fsm_v_c   = fsm_v & use_client;
  assign mem_rdy_m = mem_rdy | use_client;
  assign mem_rdy_c = mem_rdy | ~use_client;

  logic          m_rdy, m_new, m_done, m_v, m_lock;
  logic [PA-1:0] m_addr;
  logic [HW-1:0] m_hdr;
  logic [DW-1:0] m_data;
  logic          c_rdy, c_new, c_done, c_v, c_lock;
  logic [PA-1:0] c_addr;
  logic [HW-1:0] c_hdr;
  logic [DW-1:0] c_data;

  bp_stream_pump_out #(.master_p(1'b1)) dut_m (
    .clk_i(clk), .reset_n_i(reset_n),
    .fsm_header_i(fsm_header), .fsm_data_i(fsm_data), .fsm_v_i(fsm_v_m),
    .fsm_ready_and_o(m_rdy), .fsm_addr_o(m_addr), .fsm_new_o(m_new), .fsm_done_o(m_done),
    .mem_header_o(m_hdr), .mem_data_o(m_data), .mem_v_o(m_v), .mem_lock_o(m_lock),
    .mem_ready_and_i(mem_rdy_m)
  );

  bp_stream_pump_out #(.master_p(1'b0)) dut_c (
    .clk_i(clk), .reset_n_i(reset_n),
    .fsm_header_i(fsm_header), .fsm_data_i(fsm_data), .fsm_v_i(fsm_v_c),
    .fsm_ready_and_o(c_rdy), .fsm_addr_o(c_addr), .fsm_new_o(c_new), .fsm_done_o(c_done),
    .mem_header_o(c_hdr), .mem_data_o(c_data), .mem_v_o(c_v), .mem_lock_o(c_lock),
    .mem_ready_and_i(mem_rdy_c)
  );

  logic          o_rdy, o_new, o_done, o_v, o_lock;
  logic [PA-1:0] o_addr;
  logic [HW-1:0] o_hdr;
  logic [DW-1:0] o_data;
  assign o_rdy  = use_client ? c_rdy  : m_rdy;
  assign o_new  = use_client ? c_new  : m_new;
  assign o_done = use_client ? c_done : m_done;
  assign o_v    = use_client ? c_v    : m_v;
  assign o_lock = use_client ? c_lock : m_lock;
  assign o_addr = use_client ? c_addr : m_addr;
  assign o_hdr  = use_client ? c_hdr  : m_hdr;
  assign o_data = use_client ? c_data : m_data;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk($sformatf("%s_mem_v", tag),     o_v,    1'b0);
    chk($sformatf("%s_mem_lock", tag),  o_lock, 1'b0);
    chk($sformatf("%s_fsm_ready", tag), o_rdy,  1'b0);
    chk($sformatf("%s_fsm_new", tag),   o_new,  1'b0);
    chk($sformatf("%s_fsm_done", tag),  o_done, 1'b0);
    chk($sformatf("%s_fsm_addr", tag),  o_addr, {PA{1'b0}});
  endtask

  // Reference: a message is a list of beats whose addresses step by one word
  // through the 64-byte block starting at the critical word, wrapping at the end.
  task automatic send_msg(input logic [3:0] t, input logic [PA-1:0] a, input logic [2:0] sz,
                          input bit rnd, input int hold, input int abort_k, output int acc_hold);
    bit            master, multi, stall;
    int            n, beats, k, got, cyc, first_acc, first_pop, last_pop;
    logic [PL-1:0] pl;
    logic [DW-1:0] dat  [8];
    logic [PA-1:0] badr [8];
    logic [HW-1:0] ehdr [8];
    logic [HW-1:0] hdr_in, p_hdr;
    logic [DW-1:0] p_data;
    logic          p_v, p_lock;

    master = !use_client;
    n = (1 << sz) / 8;
    if (n < 1) n = 1;
    if (n > 8) n = 8;
    multi = (master ? (t == WR || t == UCWR) : (t == RD || t == UCRD)) && (n > 1);
    beats = multi ? n : 1;
    pl = PL'($urandom);
    hdr_in = {pl, t, sz, a};
    for (int i = 0; i < 8; i++) begin
      dat[i]  = {$urandom, $urandom};
      badr[i] = {a[PA-1:6], 6'b0} + PA'((a[5:0] + 8 * i) % 64);
`ifdef BP_STREAM_PUMP_OUT_BEAT_ADDR_EN
      ehdr[i] = {pl, t, sz, badr[i]};
`else
      ehdr[i] = {pl, t, sz, a};
`endif
    end

    acc_hold = 0; k = 0; got = 0; cyc = 0; stall = 0;
    first_acc = -1; first_pop = -1; last_pop = -1;
    p_hdr = '0; p_data = '0; p_v = 0; p_lock = 0;
    while ((k < beats || got < beats) && cyc < 300) begin
      @(posedge clk); #1;
      if (abort_k >= 0 && k == abort_k) begin
        fsm_v = 1'b1;
        reset_n = 1'b0;
        #1;
        chk_reset("abort");
        fsm_v = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        break;
      end
      fsm_v      = (k < beats);
      fsm_header = hdr_in;
      fsm_data   = dat[k < beats ? k : 0];
      mem_rdy    = (cyc < hold) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      @(negedge clk);
      if (stall) begin
        chk("stall_v", o_v, p_v);
        chk("stall_hdr", o_hdr, p_hdr);
        chk("stall_data", o_data, p_data);
        chk("stall_lock", o_lock, p_lock);
      end
      if (fsm_v && o_rdy) begin
        chk($sformatf("fsm_addr[%0d]", k), o_addr, badr[k]);
        chk($sformatf("fsm_new[%0d]", k), o_new, (k == 0));
        chk($sformatf("fsm_done[%0d]", k), o_done, (k == beats - 1));
        if (first_acc < 0) first_acc = cyc;
        if (cyc < hold) acc_hold++;
        k++;
      end
      if (o_v && mem_rdy) begin
        if (got < beats) begin
          chk($sformatf("mem_hdr[%0d]", got), o_hdr, ehdr[got]);
          chk($sformatf("mem_data[%0d]", got), o_data, dat[got]);
          chk($sformatf("mem_lock[%0d]", got), o_lock, (got < beats - 1));
        end else begin
          chk("extra_beat_v", o_v, 1'b0);
        end
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        got++;
      end
      stall = o_v && !mem_rdy;
      p_v = o_v; p_hdr = o_hdr; p_data = o_data; p_lock = o_lock;
      cyc++;
    end

    if (abort_k < 0) begin
      chk("complete_fsm_beats", k, beats);
      chk("complete_mem_beats", got, beats);
      @(posedge clk); #1;
      fsm_v = 1'b0;
      mem_rdy = 1'b1;
      @(negedge clk);
      chk("no_dup_mem_v", o_v, 1'b0);
      chk("back_in_ready_addr", o_addr, a);
      if (!rnd && hold == 0) begin
        chk("latency", first_pop, first_acc + 1);
        chk("no_bubbles", last_pop, first_acc + beats);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int            acc;
    logic [3:0]    rt;
    logic [2:0]    rs;
    logic [PA-1:0] ra;

    use_client = 1'b0;
    fsm_v      = 1'b0;
    mem_rdy    = 1'b1;
    fsm_data   = '0;
    fsm_header = {16'h0, UCWR, 3'd6, 40'h00_8000_0010};
    reset_n    = 1'b0;
    #3;
    fsm_v = 1'b1;
    #1;
    chk_reset("reset");
    fsm_v = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Master: 8-beat uncached write starting at the critical word 0x10.
    send_msg(UCWR, 40'h00_8000_0010, 3'd6, 1'b0, 0, -1, acc);
    // Master: read is always a single beat.
    send_msg(RD,   40'h00_8000_0040, 3'd6, 1'b0, 0, -1, acc);
    // Master: 128B write saturates at 8 beats, wraps from 0x38.
    send_msg(WR,   40'h00_8000_0138, 3'd7, 1'b0, 0, -1, acc);
    // Master: 8B write is a single beat.
    send_msg(WR,   40'h00_8000_0208, 3'd3, 1'b0, 0, -1, acc);

    use_client = 1'b1;
    send_msg(RD,   40'h00_8000_0300, 3'd3, 1'b0, 0, -1, acc);
    send_msg(WR,   40'h00_8000_0310, 3'd6, 1'b0, 0, -1, acc);
    send_msg(RD,   40'h00_8000_0328, 3'd6, 1'b0, 0, -1, acc);
    send_msg(UCRD, 40'h00_8000_0330, 3'd5, 1'b0, 0, -1, acc);
    use_client = 1'b0;

    // Bus stalled for 5 cycles: only two beats fit before the buffer fills.
    send_msg(WR, 40'h00_8000_0400, 3'd6, 1'b0, 5, -1, acc);
    chk("bp_accepts_during_hold", acc, 2);

    for (int i = 0; i < 24; i++) begin
      use_client = 1'($urandom_range(0, 1));
      rt = 4'($urandom_range(0, 3));
      rs = 3'($urandom_range(0, 7));
      ra = {8'h00, $urandom};
      send_msg(rt, ra, rs, 1'b1, 0, -1, acc);
    end
    use_client = 1'b0;

    // Reset at beat 3 of 8, then a fresh single-beat message.
    send_msg(UCWR, 40'h00_8000_0510, 3'd6, 1'b0, 0, 3, acc);
    send_msg(RD,   40'h00_8000_0518, 3'd6, 1'b0, 0, -1, acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
